tile_guess_sequencer: RTL

- Front end for the game datapath. Debounces the 8 physical tile buttons (GPIO, active-low) and arbitrates simultaneous presses.
- Issues exactly one one-hot tile guess per press to the datapath over a valid/ready handshake.
- Rejects tiles already guessed this round.
- Replaces the raw SW[7:0] guess path. The control FSM's ld_play drives enable; ld_start drives clear_used.

---
 rtl/memory_matrix_pkg.sv | 26 ++
 rtl/tile_debouncer.sv | 71 +++++++
 rtl/tile_guess_sequencer.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/memory_matrix_pkg.sv
`default_nettype none
// ============================================================================
// Module      : memory_matrix_pkg
// Description : Shared constants for the memory-matrix game front end.
//               Holds the tile count and debounce defaults, the system clock
//               frequency and the tile guess sequencer state encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package memory_matrix_pkg;

    // Board geometry and debounce defaults (10 ms at 50 MHz)
    localparam int NUM_TILES_DEFAULT       = 8;
    localparam int DEBOUNCE_CYCLES_DEFAULT = 500000;
    localparam int CNT_W_DEFAULT           = 19;

    // CLOCK_50 domain
    localparam int CLK_FREQ_HZ = 50_000_000;

    // Guess sequencer state encodings
    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] ARB      = 2'd1;
    localparam logic [1:0] OFFER    = 2'd2;
    localparam logic [1:0] WAIT_REL = 2'd3;

endpackage
`default_nettype wire

// File: rtl/tile_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : tile_debouncer
// Description : One-bit button conditioner. Two-flop synchronizer on the raw
//               active-low pin, inverted so pressed = 1, followed by a
//               consecutive-sample debounce counter.
// Ports       : clk       - system clock
//               rst       - synchronous active-high reset
//               i_btn_n   - raw asynchronous button, active-low
//               o_level   - debounced pressed level
//               o_rise    - one-cycle pulse on the edge after a 0->1 flip
// Revision    : 1.0 - initial release
// ============================================================================
import memory_matrix_pkg::*;

module tile_debouncer #(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int CNT_W           = CNT_W_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn_n,
    output logic o_level,
    output logic o_rise
);

    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic             r_rise;
    logic [CNT_W-1:0] r_cnt;
    logic             w_sample;
    logic             w_differ;

    assign w_sample = ~r_sync2;
    assign w_differ = w_sample ^ r_level;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_btn_n;
            r_sync2 <= r_sync1;
            r_rise  <= 1'b0;
            if (w_differ) begin
                // The final differing sample flips the level on this edge,
                // so the level moves after exactly DEBOUNCE_CYCLES samples.
                if (r_cnt == c_cnt_last) begin
                    r_level <= w_sample;
                    r_rise  <= w_sample;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_level = r_level;
    assign o_rise  = r_rise;

endmodule
`default_nettype wire

// File: rtl/tile_guess_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tile_guess_sequencer
// Description : Game datapath front end. Debounces the tile buttons,
//               arbitrates simultaneous presses (lowest index wins), rejects
//               tiles already used this round and offers one one-hot guess
//               per press over a valid/ready handshake.
// Ports       : clk, reset    - clock, synchronous active-high reset
//               enable        - guessing allowed (control ld_play)
//               clear_used    - clears used_mask (control ld_start)
//               btn_n         - raw tile buttons, active-low
//               guess_ready   - datapath accepts the guess this cycle
//               guess_valid   - guess offered
//               guess_tile    - one-hot guessed tile, 0 when not valid
//               guess_repeat  - one-cycle pulse, pressed tile already used
//               used_mask     - tiles accepted this round
//               any_pressed   - OR of debounced pressed levels
// Revision    : 1.0 - initial release
// ============================================================================
import memory_matrix_pkg::*;

module tile_guess_sequencer #(
    parameter int NUM_TILES       = NUM_TILES_DEFAULT,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int CNT_W           = CNT_W_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 clear_used,
    input  logic [NUM_TILES-1:0] btn_n,
    input  logic                 guess_ready,
    output logic                 guess_valid,
    output logic [NUM_TILES-1:0] guess_tile,
    output logic                 guess_repeat,
    output logic [NUM_TILES-1:0] used_mask,
    output logic                 any_pressed
);

    logic [1:0]           r_state;
    logic [NUM_TILES-1:0] r_pending;
    logic [NUM_TILES-1:0] r_tile;
    logic [NUM_TILES-1:0] r_used;
    logic                 r_valid;
    logic                 r_repeat;
    logic                 r_any;

    logic [NUM_TILES-1:0] w_level;
    logic [NUM_TILES-1:0] w_rise;
    logic [NUM_TILES-1:0] w_sel;
    logic                 w_accept;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_TILES; gi++) begin : g_tile
            tile_debouncer #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .CNT_W           (CNT_W)
            ) u_deb (
                .clk     (clk),
                .rst     (reset),
                .i_btn_n (btn_n[gi]),
                .o_level (w_level[gi]),
                .o_rise  (w_rise[gi])
            );
        end
    endgenerate

    // Isolate the lowest set pending bit (two's-complement trick).
    assign w_sel    = r_pending & (~r_pending + NUM_TILES'(1));
    // Dropping enable in OFFER aborts even if ready is high.
    assign w_accept = (r_state == OFFER) && enable && guess_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_pending <= '0;
            r_tile    <= '0;
            r_used    <= '0;
            r_valid   <= 1'b0;
            r_repeat  <= 1'b0;
            r_any     <= 1'b0;
        end else begin
            r_repeat <= 1'b0;
            r_any    <= |w_level;

            // Clear takes priority over a coincident acceptance.
            if (clear_used) begin
                r_used <= '0;
            end else if (w_accept) begin
                r_used <= r_used | r_tile;
            end

            case (r_state)
                IDLE: begin
                    if (enable) begin
                        r_pending <= r_pending | w_rise;
                    end
                    if (|r_pending) begin
                        r_state <= ARB;
                    end
                end
                ARB: begin
                    // Losing simultaneous presses are dropped here.
                    r_pending <= '0;
                    if (|(w_sel & r_used)) begin
                        r_repeat <= 1'b1;
                        r_state  <= WAIT_REL;
                    end else begin
                        r_tile  <= w_sel;
                        r_valid <= 1'b1;
                        r_state <= OFFER;
                    end
                end
                OFFER: begin
                    if (!enable || guess_ready) begin
                        r_tile  <= '0;
                        r_valid <= 1'b0;
                        r_state <= WAIT_REL;
                    end
                end
                WAIT_REL: begin
                    if (!(|w_level)) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign guess_valid  = r_valid;
    assign guess_tile   = r_tile;
    assign guess_repeat = r_repeat;
    assign used_mask    = r_used;
    assign any_pressed  = r_any;

endmodule
`default_nettype wire
